// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU opcodes, RV32I decode constants, FSM encoding and issue metadata.
// No logic; latency and backpressure n/a.
package alu_issue_ctrl_pkg;

  localparam logic [2:0] ALU_NOP  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BLTU    = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BR_EQ  = 2'd0,
    BR_NE  = 2'd1,
    BR_LT  = 2'd2,
    BR_LTU = 2'd3
  } br_kind_t;

  typedef struct packed {
    logic       we;
    logic [4:0] rd;
    logic       is_branch;
    br_kind_t   br_kind;
    logic       illegal;
  } meta_t;

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational RV32I ALU/branch decode: opcode/funct fields to ALUOp and control flags.
// Latency 0; no handshake, so no backpressure.
module alu_op_decode
  import alu_issue_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3
) (
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               f7b5,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               use_imm,
  output logic               is_branch,
  output br_kind_t           br_kind,
  output logic               illegal
);

  always_comb begin
    alu_op    = ALUOP_W'(ALU_NOP);
    use_imm   = 1'b0;
    is_branch = 1'b0;
    br_kind   = BR_EQ;
    illegal   = 1'b0;
    case (opcode)
      OPC_R, OPC_I: begin
        use_imm = (opcode == OPC_I);
        case (funct3)
          // funct7[5] selects SUB only for register-register forms
          F3_ADD_SUB: alu_op = (opcode == OPC_R && f7b5) ? ALUOP_W'(ALU_SUB) : ALUOP_W'(ALU_ADD);
          F3_AND:     alu_op = ALUOP_W'(ALU_AND);
          F3_OR:      alu_op = ALUOP_W'(ALU_OR);
          F3_SLT:     alu_op = ALUOP_W'(ALU_SLT);
          F3_SLTU:    alu_op = ALUOP_W'(ALU_SLTU);
          default:    illegal = 1'b1;
        endcase
      end
      OPC_B: begin
        is_branch = 1'b1;
        case (funct3)
          F3_BEQ:  begin alu_op = ALUOP_W'(ALU_SUB);  br_kind = BR_EQ;  end
          F3_BNE:  begin alu_op = ALUOP_W'(ALU_SUB);  br_kind = BR_NE;  end
          F3_BLT:  begin alu_op = ALUOP_W'(ALU_SLT);  br_kind = BR_LT;  end
          F3_BLTU: begin alu_op = ALUOP_W'(ALU_SLTU); br_kind = BR_LTU; end
          default: begin is_branch = 1'b0; illegal = 1'b1; end
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one RV32I ALU/branch op to an external ALU and returns result/branch/writeback info.
// Latency: accept edge, one EXEC cycle, response valid after the next edge; 1 instr per 2 cycles.
// Backpressure: response held stable while out_ready=0; in_ready follows out_ready in RESP.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_inst,
  input  logic [XLEN-1:0]    in_rs1,
  input  logic [XLEN-1:0]    in_rs2,
  output logic [XLEN-1:0]    alu_a,
  output logic [XLEN-1:0]    alu_b,
  output logic [ALUOP_W-1:0] alu_op,
  input  logic [XLEN-1:0]    alu_c,
  input  logic               alu_zero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic               out_zero,
  output logic               out_taken,
  output logic               out_we,
  output logic [4:0]         out_rd,
  output logic               out_illegal
);

  state_t             state;
  meta_t              meta;
  logic [ALUOP_W-1:0] dec_op;
  logic               dec_use_imm;
  logic               dec_branch;
  br_kind_t           dec_br_kind;
  logic               dec_illegal;
  logic [XLEN-1:0]    imm_sext;
  logic               accept;
  logic               exec_taken;
  logic               unused_rs1_field;

  alu_op_decode #(.ALUOP_W(ALUOP_W)) u_decode (
    .opcode    (in_inst[6:0]),
    .funct3    (in_inst[14:12]),
    .f7b5      (in_inst[30]),
    .alu_op    (dec_op),
    .use_imm   (dec_use_imm),
    .is_branch (dec_branch),
    .br_kind   (dec_br_kind),
    .illegal   (dec_illegal)
  );

  // Register indices are resolved upstream; only the values arrive here.
  assign unused_rs1_field = ^in_inst[19:15];

  assign imm_sext  = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign in_ready  = !rst && ((state == ST_IDLE) || (state == ST_RESP && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_RESP);

  always_comb begin
    exec_taken = 1'b0;
    if (meta.is_branch) begin
      case (meta.br_kind)
        BR_EQ:   exec_taken = alu_zero;
        BR_NE:   exec_taken = !alu_zero;
        default: exec_taken = alu_c[0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      meta        <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_taken   <= 1'b0;
      out_we      <= 1'b0;
      out_rd      <= '0;
      out_illegal <= 1'b0;
    end else begin
      case (state)
        ST_EXEC: begin
          out_result  <= meta.illegal ? '0 : alu_c;
          out_zero    <= alu_zero;
          out_taken   <= exec_taken;
          out_we      <= meta.we;
          out_rd      <= meta.rd;
          out_illegal <= meta.illegal;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (out_ready && !accept) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Accept overrides the RESP->IDLE step so a handshake pair chains straight into EXEC.
      if (accept) begin
        alu_a          <= dec_illegal ? '0 : in_rs1;
        alu_b          <= dec_illegal ? '0 : (dec_use_imm ? imm_sext : in_rs2);
        alu_op         <= dec_op;
        meta.we        <= !dec_illegal && !dec_branch && (in_inst[11:7] != 5'd0);
        meta.rd        <= dec_branch ? 5'd0 : in_inst[11:7];
        meta.is_branch <= dec_branch;
        meta.br_kind   <= dec_br_kind;
        meta.illegal   <= dec_illegal;
        state          <= ST_EXEC;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU on the alu_* ports.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_inst, in_rs1, in_rs2;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [2:0]  alu_op;
  logic        alu_zero;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_zero, out_taken, out_we, out_illegal;
  logic [4:0]  out_rd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Reference ALU: NOP=0 ADD=1 SUB=2 AND=3 OR=4 SLT=5 SLTU=6
  always_comb begin
    alu_c = 32'd0;
    case (alu_op)
      3'd1: alu_c = alu_a + alu_b;
      3'd2: alu_c = alu_a - alu_b;
      3'd3: alu_c = alu_a & alu_b;
      3'd4: alu_c = alu_a | alu_b;
      3'd5: alu_c = {31'd0, $signed(alu_a) < $signed(alu_b)};
      3'd6: alu_c = {31'd0, alu_a < alu_b};
      default: alu_c = 32'd0;
    endcase
  end
  assign alu_zero = (alu_c == 32'd0);

  alu_issue_ctrl #(.XLEN(32), .ALUOP_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_c(alu_c), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_taken(out_taken),
    .out_we(out_we), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue from IDLE, check latency and response fields, then retire it.
  task automatic run(input string tag, input logic [31:0] inst, input logic [31:0] rs1,
                     input logic [31:0] rs2, input logic [31:0] e_res, input logic e_zero,
                     input logic e_taken, input logic e_we, input logic [4:0] e_rd,
                     input logic e_ill);
    chk({tag, ".in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_inst = inst; in_rs1 = rs1; in_rs2 = rs2;
    tick();
    in_valid = 1'b0;
    chk({tag, ".valid_exec"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".in_ready_exec"}, {31'd0, in_ready}, 32'd0);
    tick();
    chk({tag, ".valid_resp"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".result"}, out_result, e_res);
    if (!e_ill) chk({tag, ".zero"}, {31'd0, out_zero}, {31'd0, e_zero});
    chk({tag, ".taken"}, {31'd0, out_taken}, {31'd0, e_taken});
    chk({tag, ".we"}, {31'd0, out_we}, {31'd0, e_we});
    if (!e_ill) chk({tag, ".rd"}, {27'd0, out_rd}, {27'd0, e_rd});
    chk({tag, ".illegal"}, {31'd0, out_illegal}, {31'd0, e_ill});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".valid_done"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'd0; in_rs1 = 32'd0; in_rs2 = 32'd0;
    tick(); tick();
    chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.alu_a", alu_a, 32'd0);
    chk("rst.result", out_result, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst.release_ready", {31'd0, in_ready}, 32'd1);

    // add x0,x1,x2 : rd=0 so no writeback
    run("add_x0", 32'h0020_8033, 32'hA0, 32'h0A, 32'hAA, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("add.alu_op", {29'd0, alu_op}, 32'd1);
    run("add_x3", 32'h0020_81B3, 32'hA0, 32'h0A, 32'hAA, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0);
    run("sub", 32'h4020_81B3, 32'hA0, 32'h0A, 32'h96, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0);
    run("sub_zero", 32'h4020_81B3, 32'hA0, 32'hA0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0);
    run("beq", 32'h0020_8063, 32'h5, 32'h5, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    run("bne", 32'h0020_9063, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    run("blt", 32'h0020_C063, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    run("bltu", 32'h0020_E063, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    run("addi", 32'hFFF0_8293, 32'h10, 32'h1234, 32'h0F, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
    chk("addi.alu_b_sext", alu_b, 32'hFFFF_FFFF);
    run("illegal", 32'h0000_A283, 32'h55, 32'h66, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    chk("illegal.alu_a", alu_a, 32'd0);
    chk("illegal.alu_b", alu_b, 32'd0);
    chk("illegal.alu_op", {29'd0, alu_op}, 32'd0);

    // Backpressure: response held for 5 cycles while a new request waits
    in_valid = 1'b1; in_inst = 32'h0020_81B3; in_rs1 = 32'h5; in_rs2 = 32'h6;
    tick();
    in_inst = 32'h4020_8233; in_rs1 = 32'h20; in_rs2 = 32'h8;  // sub x4
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", {31'd0, out_valid}, 32'd1);
      chk("bp.result", out_result, 32'hB);
      chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("b2b.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b.exec_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("b2b.valid", {31'd0, out_valid}, 32'd1);
    chk("b2b.result", out_result, 32'h18);
    chk("b2b.rd", {27'd0, out_rd}, 32'd4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset asserted mid-EXEC drops the transaction
    in_valid = 1'b1; in_inst = 32'h0020_81B3; in_rs1 = 32'h7; in_rs2 = 32'h9;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstx.in_ready", {31'd0, in_ready}, 32'd0);
    chk("rstx.alu_a", alu_a, 32'd0);
    tick(); tick();
    chk("rstx.valid", {31'd0, out_valid}, 32'd0);
    chk("rstx.result", out_result, 32'd0);
    chk("rstx.we", {31'd0, out_we}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rstx.valid_after", {31'd0, out_valid}, 32'd0);
    run("post_rst_add", 32'h0020_81B3, 32'h7, 32'h9, 32'h10, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
